stopwatch_ctrl: RTL

Control FSM for the lab2 stopwatch datapath. It turns the start/stop, lap and clear buttons into run/pause/lap/clear sequencing, and owns the elapsed-time counter, which advances on each rising edge of the 1 kHz divider output. It drives elapsed_time and a lap-frozen display_time into the binary-to-digits / seven-segment chain. It sits between the board buttons, clock_divider and binary_to_digits.

---
 rtl/stopwatch_pkg.sv | 6 +
 rtl/button_debounce.sv | 27 ++
 rtl/stopwatch_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and counter sizing for the stopwatch control slice
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} sw_state_t;
  localparam int COUNT_W = $clog2(10000);
  localparam int DEFAULT_MAX = 9999;
endpackage

// File: rtl/button_debounce.sv
// button_debounce: filtered level follows the raw button only after CYCLES consecutive differing samples
module button_debounce #(
  parameter int CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_level
);
  localparam int CW = $clog2(CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          r_level;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level <= i_btn;
      r_cnt   <= '0;
    end else if (i_btn == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(CYCLES - 1)) begin
      r_level <= i_btn;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_level = r_level;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear FSM and elapsed counter; STOPWATCH_CTRL_DEBOUNCE_EN adds button debouncing
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MAX_COUNT = DEFAULT_MAX,
  parameter bit SATURATE  = 1'b1
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 1000000
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_1khz,
  input  logic               btn_start_stop,
  input  logic               btn_lap,
  input  logic               btn_clear,
  output logic               count_en,
  output logic [COUNT_W-1:0] elapsed_time,
  output logic [COUNT_W-1:0] display_time,
  output logic               lap_active,
  output logic               overflow,
  output logic [1:0]         state_o
);
  logic [2:0]         w_lvl;
  logic [2:0]         r_btn, r_btn_q;
  logic               r_tick, r_tick_q;
  logic [2:0]         w_press;
  logic               w_tick, w_count, w_at_max, w_zero, w_cap;
  sw_state_t          r_state, w_next;
  logic [COUNT_W-1:0] r_elapsed, r_lap;
  logic               r_overflow, r_count_en, r_lap_active;
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_ss  (.clk(clk), .reset(reset), .i_btn(btn_start_stop), .o_level(w_lvl[0]));
  button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_lap (.clk(clk), .reset(reset), .i_btn(btn_lap),        .o_level(w_lvl[1]));
  button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_clr (.clk(clk), .reset(reset), .i_btn(btn_clear),      .o_level(w_lvl[2]));
`else
  assign w_lvl = {btn_clear, btn_lap, btn_start_stop};
`endif
  // bit 0 start/stop, bit 1 lap, bit 2 clear
  assign w_press  = r_btn & ~r_btn_q;
  assign w_tick   = r_tick & ~r_tick_q;
  assign w_count  = w_tick & (r_state == RUN || r_state == LAP);
  assign w_at_max = r_elapsed == COUNT_W'(MAX_COUNT);
  always_comb begin
    w_next = r_state;
    w_zero = 1'b0;
    w_cap  = 1'b0;
    case (r_state)
      IDLE: begin
        w_zero = w_press[2];
        w_next = (~w_press[2] & w_press[0]) ? RUN : IDLE;
      end
      PAUSE: begin
        w_zero = w_press[2];
        w_next = w_press[2] ? IDLE : w_press[0] ? RUN : PAUSE;
      end
      default: begin
        w_cap  = ~w_press[0] & w_press[1];
        w_next = w_press[0] ? PAUSE : w_press[1] ? LAP : r_state;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn        <= w_lvl;
      r_btn_q      <= w_lvl;
      r_tick       <= tick_1khz;
      r_tick_q     <= tick_1khz;
      r_state      <= IDLE;
      r_count_en   <= 1'b0;
      r_lap_active <= 1'b0;
      r_elapsed    <= '0;
      r_lap        <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_btn        <= w_lvl;
      r_btn_q      <= r_btn;
      r_tick       <= tick_1khz;
      r_tick_q     <= r_tick;
      r_state      <= w_next;
      r_count_en   <= w_next == RUN || w_next == LAP;
      r_lap_active <= w_next == LAP;
      if (w_zero) begin
        r_elapsed  <= '0;
        r_overflow <= 1'b0;
      end else if (w_count) begin
        r_overflow <= r_overflow | w_at_max;
        r_elapsed  <= w_at_max ? (SATURATE ? r_elapsed : '0) : r_elapsed + 1'b1;
      end
      // capture uses the pre-increment value of a same-cycle tick
      if (w_zero) r_lap <= '0;
      else if (w_cap) r_lap <= r_elapsed;
    end
  end
  assign count_en     = r_count_en;
  assign lap_active   = r_lap_active;
  assign elapsed_time = r_elapsed;
  assign display_time = r_lap_active ? r_lap : r_elapsed;
  assign overflow     = r_overflow;
  assign state_o      = r_state;
endmodule
